// File: rtl/pop_pkg.sv
// pop_pkg: shared widths and FSM state encoding for the population-count expander.
package pop_pkg;
    localparam int DATA_W  = 128;
    localparam int CHUNK_W = 16;
    localparam int CNT_W   = 8;
    localparam int ROT_W   = 7;
    localparam int N_CHUNK = DATA_W / CHUNK_W;

    typedef enum logic [1:0] {IDLE, BUILD, ROT, OUT} pop_exp_state_t;
endpackage

// File: rtl/pop_chunk_therm.sv
// pop_chunk_therm: 5-bit count to 16-bit LSB-aligned thermometer, saturating at all ones.
module pop_chunk_therm import pop_pkg::*; (
    input  logic [4:0]         n,
    output logic [CHUNK_W-1:0] therm
);
    assign therm = n >= 5'd16 ? '1 : (16'd1 << n) - 16'd1;
endmodule

// File: rtl/pop_expand.sv
// pop_expand: builds a 128-bit word holding cnt contiguous ones starting at bit rot.
// Chunks are filled one per cycle, then rotated by one binary stage of rot per cycle.
module pop_expand import pop_pkg::*; (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CNT_W-1:0]  cnt,
    input  logic [ROT_W-1:0]  rot,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              err
);
    pop_exp_state_t state, state_n;
    logic [2:0] idx;
    logic [CNT_W-1:0] cnt_q;
    logic [ROT_W-1:0] rot_q;
    logic err_q;
    logic [DATA_W-1:0] work, work_rot;
    logic [2*DATA_W-1:0] dbl;
    logic [ROT_W:0] rot_x;
    logic signed [8:0] diff;
    logic [4:0] chunk_n;
    logic [CHUNK_W-1:0] therm;
    logic [7:0] amt;

    pop_chunk_therm u_therm (.n(chunk_n), .therm(therm));

    assign in_ready = state == IDLE;

    // Signed difference so chunks beyond the count clamp to zero ones.
    always_comb begin
        diff     = $signed({1'b0, cnt_q}) - $signed({2'b00, idx, 4'b0000});
        chunk_n  = diff < 0 ? 5'd0 : diff > 9'sd16 ? 5'd16 : diff[4:0];
        rot_x    = {1'b0, rot_q};
        amt      = rot_x[idx] ? 8'd1 << idx : 8'd0;
        dbl      = {work, work} << amt;
        work_rot = dbl[2*DATA_W-1:DATA_W];
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = in_valid ? BUILD : IDLE;
            BUILD:   state_n = idx == 3'd7 ? ROT : BUILD;
            ROT:     state_n = idx == 3'd6 ? OUT : ROT;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) state <= !rst_n ? IDLE : state_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx       <= '0;
            cnt_q     <= '0;
            rot_q     <= '0;
            err_q     <= 1'b0;
            work      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            err       <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            out_data  <= '0;
            err       <= 1'b0;
            case (state)
                IDLE: if (in_valid) begin
                    cnt_q <= cnt > 8'd128 ? 8'd128 : cnt;
                    rot_q <= rot;
                    err_q <= cnt > 8'd128;
                    work  <= '0;
                    idx   <= '0;
                end
                BUILD: begin
                    work[{idx, 4'b0000} +: CHUNK_W] <= therm;
                    idx <= idx + 3'd1;
                end
                ROT: begin
                    work <= work_rot;
                    idx  <= idx + 3'd1;
                    if (idx == 3'd6) begin
                        out_valid <= 1'b1;
                        out_data  <= work_rot;
                        err       <= err_q;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_pop_expand.sv
// tb_pop_expand: random and directed requests scored against a bit-by-bit run model.
module tb_pop_expand;
    logic clk = 0, rst_n = 0, in_valid = 0, in_ready, out_valid, err;
    logic [7:0] cnt = 0;
    logic [6:0] rot = 0;
    logic [127:0] out_data;
    int checks = 0, failures = 0, cyc = 0;

    typedef struct {
        logic [127:0] d;
        logic         e;
        int           n;
        int           c;
    } exp_t;
    exp_t sb[$];
    int acc[$];

    pop_expand dut (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
                    .cnt(cnt), .rot(rot), .out_valid(out_valid), .out_data(out_data), .err(err));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [127:0] model(int c, int r);
        logic [127:0] v = '0;
        int n = c > 128 ? 128 : c;
        for (int i = 0; i < n; i++) v[(r + i) % 128] = 1'b1;
        return v;
    endfunction

    task automatic check(string name, logic [127:0] act, logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Accept observer: the request is taken at the next edge when valid meets ready.
    always @(negedge clk)
        if (rst_n && in_valid && in_ready) begin
            sb.push_back('{model(cnt, rot), cnt > 128, cnt > 128 ? 128 : int'(cnt), cyc});
            acc.push_back(cyc);
        end

    always @(negedge clk) begin
        exp_t e;
        if (out_valid) begin
            if (sb.size() == 0) check("unexpected_out_valid", 1, 0);
            else begin
                e = sb.pop_front();
                check("out_data", out_data, e.d);
                check("err", err, e.e);
                check("latency", cyc - e.c, 16);
                check("loopback_popcount", $countones(out_data), e.n);
            end
        end else if (rst_n) begin
            check("idle_out_data", out_data, 0);
            check("idle_err", err, 0);
        end
    end

    task automatic send(int c, int r);
        int t = 0;
        while (!in_ready && t < 100) begin
            @(posedge clk); #2;
            t++;
        end
        if (!in_ready) check("in_ready_timeout", 0, 1);
        in_valid = 1; cnt = 8'(c); rot = 7'(r);
        @(posedge clk); #2;
        in_valid = 0;
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(posedge clk); #2;
            t++;
        end
        check("drain_timeout", sb.size(), 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2 rst_n = 1;
        @(negedge clk);
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", out_data, 0);
        check("reset_err", err, 0);
        @(posedge clk); #2;

        send(0, 0); send(20, 0); send(3, 126); send(128, 37); send(200, 90); send(129, 0); send(255, 127);
        drain();
        check("directed_cnt20", model(20, 0), 128'h000FFFFF);
        check("directed_wrap", model(3, 126), {2'b11, 125'b0, 1'b1});

        acc.delete();
        in_valid = 1; cnt = 8'd50; rot = 7'd10;
        repeat (35) @(posedge clk);
        #2 in_valid = 0;
        check("held_valid_accepts", acc.size(), 3);
        if (acc.size() == 3) begin
            check("accept_gap_0", acc[1] - acc[0], 17);
            check("accept_gap_1", acc[2] - acc[1], 17);
        end
        drain();

        send(77, 5);
        repeat (4) @(posedge clk);
        #2 rst_n = 0;
        @(posedge clk);
        #2 rst_n = 1;
        sb.delete();
        @(negedge clk);
        check("post_reset_in_ready", in_ready, 1);
        check("post_reset_out_valid", out_valid, 0);
        check("post_reset_out_data", out_data, 0);
        check("post_reset_err", err, 0);
        repeat (20) @(posedge clk);
        #2;

        for (int c = 0; c <= 128; c++) send(c, $urandom_range(0, 127));
        repeat (20) send($urandom_range(0, 255), $urandom_range(0, 127));
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
